fetch_pc_ctrl: RTL

Upstream companion of the Y86 fetch stage. It owns the predicted-PC register and drives PC_i into fetch. It selects the next fetch PC from three sources: the predicted PC, a mispredicted-branch fall-through, or a return address. A 3-state machine stops issue after ret/halt/invalid/imem_error and resumes on redirect, and the block also reports fetch status and counts issued instructions.

---
 rtl/fetch_pc_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_pc_ctrl.sv
// Owns the predicted PC and picks the fetch address from predPC, mispredict fall-through or ret address.
// pc_o is combinational; predPC/state/count update next edge; stall_i freezes them unless a mispredict redirects.
module fetch_pc_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             stall_i,
    input  logic [3:0]       icode_i,
    input  logic [63:0]      valC_i,
    input  logic [63:0]      valP_i,
    input  logic             instr_valid_i,
    input  logic             imem_error_i,
    input  logic [3:0]       M_icode_i,
    input  logic             M_cnd_i,
    input  logic [63:0]      M_valA_i,
    input  logic [3:0]       W_icode_i,
    input  logic [63:0]      W_valM_i,
    output logic [63:0]      pc_o,
    output logic [63:0]      pred_pc_o,
    output logic             bubble_o,
    output logic [2:0]       stat_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] issue_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_RET_WAIT = 2'd1,
        ST_STOP     = 2'd2
    } state_e;

    localparam logic [3:0] I_HALT = 4'h1;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q;
    logic [63:0]      pred_pc_q;
    logic [CNT_W-1:0] issue_cnt_q;

    logic        mispredict;
    logic        retdone;
    logic        bubble;
    logic        advance;
    logic [63:0] f_pred;
    logic [2:0]  f_stat;
    state_e      f_next;

    assign mispredict = (M_icode_i == I_JXX) && !M_cnd_i;
    assign retdone    = (W_icode_i == I_RET);

    always_comb begin
        pc_o = pred_pc_q;
        if (mispredict) begin
            pc_o = M_valA_i;
        end else if (retdone) begin
            pc_o = W_valM_i;
        end
    end

    assign f_pred = ((icode_i == I_JXX) || (icode_i == I_CALL)) ? valC_i : valP_i;

    always_comb begin
        f_stat = S_AOK;
        if (imem_error_i) begin
            f_stat = S_ADR;
        end else if (!instr_valid_i) begin
            f_stat = S_INS;
        end else if (icode_i == I_HALT) begin
            f_stat = S_HLT;
        end
    end

    always_comb begin
        f_next = ST_RUN;
        if (f_stat != S_AOK) begin
            f_next = ST_STOP;
        end else if (icode_i == I_RET) begin
            f_next = ST_RET_WAIT;
        end
    end

    // A mispredict always clears the bubble, so it both redirects and counts even under stall.
    assign bubble  = ((state_q == ST_RET_WAIT) && !retdone && !mispredict) ||
                     ((state_q == ST_STOP) && !mispredict);
    assign advance = mispredict || (!bubble && !stall_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pred_pc_q   <= RESET_PC;
            state_q     <= ST_RUN;
            issue_cnt_q <= '0;
        end else if (advance) begin
            pred_pc_q   <= f_pred;
            state_q     <= f_next;
            issue_cnt_q <= issue_cnt_q + CNT_ONE;
        end
    end

    assign pred_pc_o   = pred_pc_q;
    assign bubble_o    = bubble;
    assign stat_o      = bubble ? S_AOK : f_stat;
    assign state_o     = state_q;
    assign issue_cnt_o = issue_cnt_q;

endmodule
